// File: rtl/bar_handshake_driver.sv
// Transmit side of the bar ready/valid handshake: FIFO-buffered operand pairs with round-robin completion tokens.
// Define BAR_HS_DRIVER_ASSERT_EN to compile the embedded protocol assertions.
module bar_handshake_driver #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2,
   parameter int LANES = 3
) (
   input  logic                 CLK,
   input  logic                 ASYNCRESETN,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   output logic                 handshake_valid,
   input  logic                 handshake_ready,
   output logic [2*WIDTH-1:0]   handshake_data,
   output logic                 out,
   output logic [LANES-1:0]     handshake_arr_valid,
   input  logic [LANES-1:0]     handshake_arr_ready
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int RR_W  = (LANES > 1) ? $clog2(LANES) : 1;

   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [RR_W-1:0]    rr_q, rr_d;
   logic [LANES-1:0]   lane_pend_q, lane_pend_d;
   logic [2*WIDTH-1:0] head;
   logic               push;
   logic               fire;

   assign in_ready            = ASYNCRESETN && (count_q < CNT_W'(DEPTH));
   assign handshake_valid     = (count_q != '0) && !lane_pend_q[rr_q];
   assign head                = mem_q[rd_ptr_q];
   assign handshake_data      = head;
   assign out                 = (|head[WIDTH-1:0]) ^ (&head[2*WIDTH-1:WIDTH]);
   assign handshake_arr_valid = lane_pend_q;
   assign push                = in_valid && in_ready;
   assign fire                = handshake_valid && handshake_ready;

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rr_d        = rr_q;
      lane_pend_d = lane_pend_q & ~handshake_arr_ready;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (fire) begin
         rd_ptr_d          = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         rr_d              = (rr_q == RR_W'(LANES - 1)) ? '0 : rr_q + 1'b1;
         lane_pend_d[rr_q] = 1'b1;
      end
      case ({push, fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: storage is reset too, so data/out read as zero while the FIFO is empty after reset.
   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rr_q        <= '0;
         lane_pend_q <= '0;
      end else begin
         if (push) mem_q[wr_ptr_q] <= {in2, in1};
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rr_q        <= rr_d;
         lane_pend_q <= lane_pend_d;
      end
   end

`ifdef BAR_HS_DRIVER_ASSERT_EN
   a_head_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      handshake_valid && !handshake_ready |=> $stable({handshake_valid, handshake_data, out}));

   for (genvar k = 0; k < LANES; k++) begin : g_lane_assert
      a_lane_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
         lane_pend_q[k] && !handshake_arr_ready[k] |=> lane_pend_q[k]);
   end

   a_count_range: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      count_q <= CNT_W'(DEPTH));

   a_fire_lane_free: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      fire |-> !lane_pend_q[rr_q]);
`endif

endmodule

// File: tb/tb_bar_handshake_driver.sv
// Directed bench for bar_handshake_driver: reset, single transfer, backpressure, lane stall, async reset, wrap.
module tb_bar_handshake_driver;

   logic       CLK;
   logic       ASYNCRESETN;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in1;
   logic [3:0] in2;
   logic       handshake_valid;
   logic       handshake_ready;
   logic [7:0] handshake_data;
   logic       out;
   logic [2:0] handshake_arr_valid;
   logic [2:0] handshake_arr_ready;

   int checks   = 0;
   int failures = 0;

   bar_handshake_driver #(.WIDTH(4), .DEPTH(2), .LANES(3)) dut (
      .CLK                 (CLK),
      .ASYNCRESETN         (ASYNCRESETN),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in1                 (in1),
      .in2                 (in2),
      .handshake_valid     (handshake_valid),
      .handshake_ready     (handshake_ready),
      .handshake_data      (handshake_data),
      .out                 (out),
      .handshake_arr_valid (handshake_arr_valid),
      .handshake_arr_ready (handshake_arr_ready)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Inputs are driven and outputs sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      ASYNCRESETN = 1'b0;
      in_valid    = 1'b0;
      tick();
      ASYNCRESETN = 1'b1;
   endtask

   initial begin
      ASYNCRESETN         = 1'b0;
      in_valid            = 1'b1;
      in1                 = 4'h0;
      in2                 = 4'h0;
      handshake_ready     = 1'b1;
      handshake_arr_ready = 3'b111;

      // T1 reset held three cycles with valid and readies asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_hs_valid", handshake_valid, 1'b0);
         check("t1_in_ready", in_ready, 1'b0);
         check("t1_arr_valid", handshake_arr_valid, 3'b000);
      end
      check("t1_data", handshake_data, 8'h00);
      check("t1_out", out, 1'b0);
      ASYNCRESETN = 1'b1;
      in_valid    = 1'b0;
      #1;
      check("t1_in_ready_rel", in_ready, 1'b1);
      tick();
      check("t1_no_xfer_valid", handshake_valid, 1'b0);
      check("t1_no_xfer_arr", handshake_arr_valid, 3'b000);

      // T2 single transfer, token held until lane 0 ready
      handshake_arr_ready = 3'b000;
      in_valid = 1'b1; in1 = 4'hF; in2 = 4'h0;
      tick();
      in_valid = 1'b0;
      check("t2_hs_valid", handshake_valid, 1'b1);
      check("t2_data", handshake_data, 8'h0F);
      check("t2_out", out, 1'b1);
      tick();
      check("t2_valid_after_fire", handshake_valid, 1'b0);
      check("t2_arr_set", handshake_arr_valid, 3'b001);
      tick();
      check("t2_arr_held", handshake_arr_valid, 3'b001);
      handshake_arr_ready = 3'b001;
      tick();
      check("t2_arr_clear", handshake_arr_valid, 3'b000);

      // T3 backpressure: two pushes fill the FIFO, third is held off
      handshake_arr_ready = 3'b111;
      handshake_ready     = 1'b0;
      in_valid = 1'b1; in1 = 4'h1; in2 = 4'h2;
      check("t3_in_ready_empty", in_ready, 1'b1);
      tick();
      check("t3_in_ready_one", in_ready, 1'b1);
      check("t3_data_p0", handshake_data, 8'h21);
      in1 = 4'h0; in2 = 4'hF;
      tick();
      check("t3_in_ready_full", in_ready, 1'b0);
      in1 = 4'h5; in2 = 4'hA;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t3_stall_in_ready", in_ready, 1'b0);
         check("t3_stall_valid", handshake_valid, 1'b1);
         check("t3_stall_data", handshake_data, 8'h21);
         check("t3_stall_out", out, 1'b1);
      end
      handshake_ready = 1'b1;
      tick();
      check("t3_drain_p1_data", handshake_data, 8'hF0);
      check("t3_drain_p1_out", out, 1'b1);
      check("t3_drain_p1_valid", handshake_valid, 1'b1);
      tick();
      in_valid = 1'b0;
      check("t3_drain_p2_data", handshake_data, 8'hA5);
      check("t3_drain_p2_valid", handshake_valid, 1'b1);
      tick();
      check("t3_drained", handshake_valid, 1'b0);

      // T4 lane stall: three fires occupy all lanes, pulse on lane 0 releases the fourth
      do_reset();
      handshake_arr_ready = 3'b000;
      handshake_ready     = 1'b1;
      in_valid = 1'b1; in1 = 4'h1; in2 = 4'h0;
      tick();
      in1 = 4'h2;
      tick();
      check("t4_arr_l0", handshake_arr_valid, 3'b001);
      check("t4_data_q1", handshake_data, 8'h02);
      in1 = 4'h3;
      tick();
      check("t4_arr_l1", handshake_arr_valid, 3'b011);
      check("t4_data_q2", handshake_data, 8'h03);
      in1 = 4'h4;
      tick();
      in_valid = 1'b0;
      check("t4_arr_l2", handshake_arr_valid, 3'b111);
      check("t4_stall_valid", handshake_valid, 1'b0);
      check("t4_data_q3", handshake_data, 8'h04);
      tick();
      check("t4_stall_hold", handshake_valid, 1'b0);
      handshake_arr_ready = 3'b001;
      tick();
      handshake_arr_ready = 3'b000;
      check("t4_release_valid", handshake_valid, 1'b1);
      check("t4_release_arr", handshake_arr_valid, 3'b110);
      tick();
      check("t4_fire_l0_valid", handshake_valid, 1'b0);
      check("t4_fire_l0_arr", handshake_arr_valid, 3'b111);

      // T5 async reset between edges with count=2 and lanes 0,1 pending
      do_reset();
      handshake_arr_ready = 3'b000;
      handshake_ready     = 1'b1;
      in_valid = 1'b1; in1 = 4'h1; in2 = 4'h1;
      tick();
      in1 = 4'h2;
      tick();
      in1 = 4'h3;
      tick();
      in1 = 4'h4;
      handshake_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check("t5_pre_valid", handshake_valid, 1'b1);
      check("t5_pre_arr", handshake_arr_valid, 3'b011);
      check("t5_pre_in_ready", in_ready, 1'b0);
      #2;
      ASYNCRESETN = 1'b0;
      #1;
      check("t5_async_valid", handshake_valid, 1'b0);
      check("t5_async_arr", handshake_arr_valid, 3'b000);
      check("t5_async_in_ready", in_ready, 1'b0);
      check("t5_async_data", handshake_data, 8'h00);
      tick();
      ASYNCRESETN = 1'b1;
      #1;
      check("t5_rel_in_ready", in_ready, 1'b1);
      check("t5_rel_empty", handshake_valid, 1'b0);
      handshake_ready = 1'b1;
      in_valid = 1'b1; in1 = 4'h7; in2 = 4'h0;
      tick();
      in_valid = 1'b0;
      check("t5_post_data", handshake_data, 8'h07);
      tick();
      check("t5_rr_zero", handshake_arr_valid, 3'b001);

      // T6 seven back-to-back transfers with lane readies tied high
      do_reset();
      handshake_arr_ready = 3'b111;
      handshake_ready     = 1'b1;
      in_valid = 1'b1; in1 = 4'h1; in2 = 4'h0;
      tick();
      check("t6_first_valid", handshake_valid, 1'b1);
      check("t6_first_data", handshake_data, 8'h01);
      for (int i = 0; i < 7; i++) begin
         logic [3:0] nx;
         logic [2:0] lane_exp;
         nx = 4'(i + 1);
         if (i + 1 < 7) begin
            in1 = nx + 4'h1;
            in2 = nx;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         lane_exp = 3'b001 << (i % 3);
         check($sformatf("t6_lane_%0d", i), handshake_arr_valid, lane_exp);
         if (i < 6) begin
            check($sformatf("t6_valid_%0d", i), handshake_valid, 1'b1);
            check($sformatf("t6_data_%0d", i), handshake_data, {nx, nx + 4'h1});
         end else begin
            check("t6_empty", handshake_valid, 1'b0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
